sr_task_queue_ctrl: RTL and testbench

// Command sequencer and arbiter for the shift-register task queue (head cell plus body cells).

---
 rtl/sr_task_queue_ctrl.sv | 157 +++++++++++++++
 tb/tb_sr_task_queue_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_task_queue_ctrl.sv
// sr_task_queue_ctrl: round-robin command sequencer for the shift-register task queue.
// Grants one enqueue/dequeue/remove at a time, strobes the queue cells and tracks occupancy.
module sr_task_queue_ctrl #(
    parameter int DEPTH  = 8,
    parameter int TID_W  = 4,
    parameter int INFO_W = 32,
    parameter int NREQ   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [2*NREQ-1:0]            req_op,
    input  logic [TID_W*NREQ-1:0]        req_tid,
    input  logic [INFO_W*NREQ-1:0]       req_info,
    output logic [NREQ-1:0]              req_ready,
    output logic                         req_err,
    output logic                         q_enqueue,
    output logic                         q_dequeue,
    output logic                         q_remove,
    output logic                         q_que_act,
    output logic                         q_que_blk,
    output logic [TID_W-1:0]             q_tid,
    output logic [INFO_W-1:0]            q_info,
    input  logic                         q_remove_hit,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;
    typedef enum logic [1:0] {OP_ENQ = 2'b00, OP_DEQ = 2'b01, OP_REM = 2'b10, OP_RSV = 2'b11} op_t;

    state_t             state, state_nx;
    op_t                op_r, win_op;
    logic [TID_W-1:0]   tid_r, win_tid;
    logic [INFO_W-1:0]  info_r, win_info;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nx, win_idx, cand;
    logic               any_valid, illegal;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PTR_W'((32'(rr_ptr) + k) % 32'(NREQ));
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_op   = OP_ENQ;
        win_tid  = '0;
        win_info = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == win_idx) begin
                win_op   = op_t'(req_op[2*i +: 2]);
                win_tid  = req_tid[TID_W*i +: TID_W];
                win_info = req_info[INFO_W*i +: INFO_W];
            end
        end
    end

    assign illegal = (win_op == OP_RSV)
                   || ((win_op == OP_ENQ) && full)
                   || (((win_op == OP_DEQ) || (win_op == OP_REM)) && empty);

    assign rr_ptr_nx = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (any_valid && !illegal) state_nx = S_ISSUE;
            S_ISSUE:  state_nx = S_SETTLE;
            S_SETTLE: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Grant/error are combinational so the requester sees them in its request cycle.
    always_comb begin
        req_ready = '0;
        req_err   = 1'b0;
        q_enqueue = 1'b0;
        q_dequeue = 1'b0;
        q_remove  = 1'b0;
        q_que_act = 1'b0;
        q_que_blk = 1'b0;
        q_tid     = '0;
        q_info    = '0;
        case (state)
            S_IDLE: begin
                if (any_valid && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    req_err            = illegal;
                end
            end
            S_ISSUE: begin
                q_tid = tid_r;
                case (op_r)
                    OP_ENQ: begin
                        q_enqueue = 1'b1;
                        q_que_act = 1'b1;
                        q_info    = info_r;
                    end
                    OP_DEQ: q_dequeue = 1'b1;
                    OP_REM: begin
                        q_remove  = 1'b1;
                        q_que_blk = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            op_r   <= OP_ENQ;
            tid_r  <= '0;
            info_r <= '0;
            count  <= '0;
        end else begin
            if ((state == S_IDLE) && any_valid) begin
                rr_ptr <= rr_ptr_nx;
                op_r   <= win_op;
                tid_r  <= win_tid;
                info_r <= win_info;
            end
            if (state == S_SETTLE) begin
                case (op_r)
                    OP_ENQ: if (!full)  count <= count + 1'b1;
                    OP_DEQ: if (!empty) count <= count - 1'b1;
                    OP_REM: if (q_remove_hit && !empty) count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sr_task_queue_ctrl.sv
// Self-checking bench for sr_task_queue_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of requesters and occupancy.
module tb_sr_task_queue_ctrl;

    localparam int DEPTH  = 8;
    localparam int TID_W  = 4;
    localparam int INFO_W = 32;
    localparam int NREQ   = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [2*NREQ-1:0]      req_op = '0;
    logic [TID_W*NREQ-1:0]  req_tid = '0;
    logic [INFO_W*NREQ-1:0] req_info = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   req_err;
    logic                   q_enqueue, q_dequeue, q_remove, q_que_act, q_que_blk;
    logic [TID_W-1:0]       q_tid;
    logic [INFO_W-1:0]      q_info;
    logic                   q_remove_hit = 1'b0;
    logic [CNT_W-1:0]       count;
    logic                   full, empty;

    sr_task_queue_ctrl #(.DEPTH(DEPTH), .TID_W(TID_W), .INFO_W(INFO_W), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_tid(req_tid),
        .req_info(req_info), .req_ready(req_ready), .req_err(req_err), .q_enqueue(q_enqueue),
        .q_dequeue(q_dequeue), .q_remove(q_remove), .q_que_act(q_que_act), .q_que_blk(q_que_blk),
        .q_tid(q_tid), .q_info(q_info), .q_remove_hit(q_remove_hit), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 = free to grant, 1 = strobe cycle, 2 = settle cycle.
    int          m_count, m_ptr, m_phase, m_op, m_tid;
    int unsigned m_info;
    bit          p_valid[NREQ];
    int          p_op[NREQ];
    int          p_tid[NREQ];
    int unsigned p_info[NREQ];
    bit          rhit;
    int          steps;
    int          grant_who[$];
    int          grant_at[$];
    bit          saw_err, saw_strobe;

    task automatic model_reset();
        m_count = 0; m_ptr = 0; m_phase = 0; m_op = 0; m_tid = 0; m_info = 0;
        for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input int op, input int tid, input int unsigned info);
        p_valid[i] = 1'b1; p_op[i] = op; p_tid[i] = tid; p_info[i] = info;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                   = p_valid[i];
            req_op[2*i +: 2]               = 2'(p_op[i]);
            req_tid[TID_W*i +: TID_W]      = TID_W'(p_tid[i]);
            req_info[INFO_W*i +: INFO_W]   = p_info[i];
        end
        q_remove_hit = rhit;
    endtask

    task automatic clear_logs();
        grant_who.delete(); grant_at.delete(); steps = 0; saw_err = 0; saw_strobe = 0;
    endtask

    // One clock: drive, check all outputs mid-cycle against the model, advance model at the edge.
    task automatic step();
        int               w;
        bit               ill;
        logic [NREQ-1:0]  e_rdy;
        logic             e_err, e_enq, e_deq, e_rem;
        logic [TID_W-1:0] e_tid;
        logic [INFO_W-1:0] e_info;
        drive();
        @(negedge clk);
        w = -1; ill = 0; e_rdy = '0; e_err = 0; e_enq = 0; e_deq = 0; e_rem = 0;
        e_tid = '0; e_info = '0;
        if (m_phase == 0) begin
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && p_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            if (w >= 0) begin
                ill = (p_op[w] == 3) || (p_op[w] == 0 && m_count == DEPTH)
                   || ((p_op[w] == 1 || p_op[w] == 2) && m_count == 0);
                if (!rst) begin e_rdy[w] = 1'b1; e_err = ill; end
            end
        end else if (m_phase == 1) begin
            e_enq = (m_op == 0); e_deq = (m_op == 1); e_rem = (m_op == 2);
            e_tid = TID_W'(m_tid);
            e_info = (m_op == 0) ? m_info : '0;
        end
        n_cmp++;
        if ({req_ready, req_err} !== {e_rdy, e_err}) begin
            n_bad++;
            $display("FAIL grant t=%0t: ready=%b err=%b, expected ready=%b err=%b",
                     $time, req_ready, req_err, e_rdy, e_err);
        end
        n_cmp++;
        if ({q_enqueue, q_dequeue, q_remove, q_que_act, q_que_blk} !== {e_enq, e_deq, e_rem, e_enq, e_rem}) begin
            n_bad++;
            $display("FAIL strobes t=%0t: enq/deq/rem/act/blk=%b, expected %b", $time,
                     {q_enqueue, q_dequeue, q_remove, q_que_act, q_que_blk}, {e_enq, e_deq, e_rem, e_enq, e_rem});
        end
        n_cmp++;
        if ({q_tid, q_info} !== {e_tid, e_info}) begin
            n_bad++;
            $display("FAIL payload t=%0t: tid=%0h info=%0h, expected tid=%0h info=%0h",
                     $time, q_tid, q_info, e_tid, e_info);
        end
        n_cmp++;
        if ({count, full, empty} !== {CNT_W'(m_count), (m_count == DEPTH), (m_count == 0)}) begin
            n_bad++;
            $display("FAIL occupancy t=%0t: count=%0d full=%b empty=%b, expected count=%0d full=%b empty=%b",
                     $time, count, full, empty, m_count, (m_count == DEPTH), (m_count == 0));
        end
        if (req_err === 1'b1) saw_err = 1;
        if ((q_enqueue | q_dequeue | q_remove) === 1'b1) saw_strobe = 1;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            case (m_phase)
                0: if (w >= 0) begin
                    grant_who.push_back(w); grant_at.push_back(steps);
                    p_valid[w] = 1'b0;
                    m_ptr = (w + 1) % NREQ;
                    if (!ill) begin
                        m_phase = 1; m_op = p_op[w]; m_tid = p_tid[w]; m_info = p_info[w];
                    end
                end
                1: m_phase = 2;
                default: begin
                    if (m_op == 0) m_count++;
                    else if (m_op == 1) m_count--;
                    else if (m_op == 2 && rhit) m_count--;
                    m_phase = 0;
                end
            endcase
        end
        steps++;
        #1;
    endtask

    task automatic reset_cycle();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rhit = 0; model_reset(); drive();
        repeat (2) @(posedge clk);
        #1;
        set_req(1, 0, 7, 32'h55);
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({count, empty, full} !== {CNT_W'(0), 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b, expected 0/1/0", count, empty, full);
        end
    endtask

    task automatic test_single_enq();
        clear_logs();
        set_req(0, 0, 3, 32'h20);
        step(); step(); step();
        n_cmp++;
        if (grant_who.size() !== 1 || grant_who[0] !== 0) begin
            n_bad++;
            $display("FAIL single_enq_grant: grants=%0d, expected one grant to req0", grant_who.size());
        end
        n_cmp++;
        if ({count, empty} !== {CNT_W'(1), 1'b0}) begin
            n_bad++;
            $display("FAIL single_enq_count: count=%0d empty=%b, expected 1/0", count, empty);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        reset_cycle();
        clear_logs();
        repeat (15) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_valid[i]) set_req(i, 0, $urandom_range(0, 15), $urandom);
            step();
        end
        n_cmp++;
        if (grant_who.size() !== 5) begin
            n_bad++;
            $display("FAIL rr_count: grants=%0d, expected 5", grant_who.size());
        end
        for (int i = 0; i < 5 && i < grant_who.size(); i++) begin
            n_cmp++;
            if (grant_who[i] !== exp_order[i]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got req%0d, expected req%0d", i, grant_who[i], exp_order[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (grant_at[i] - grant_at[i-1] !== 3) begin
                    n_bad++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, expected 3", i, grant_at[i] - grant_at[i-1]);
                end
            end
        end
    endtask

    task automatic test_full();
        for (int n = 0; n < 40 && m_count < DEPTH; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_valid[i]) set_req(i, 0, $urandom_range(0, 15), $urandom);
            step();
        end
        clear_logs();
        repeat (6) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_valid[i]) set_req(i, 0, $urandom_range(0, 15), $urandom);
            step();
        end
        n_cmp++;
        if ({saw_err, saw_strobe, count, full} !== {1'b1, 1'b0, CNT_W'(DEPTH), 1'b1}) begin
            n_bad++;
            $display("FAIL enq_when_full: err=%b strobe=%b count=%0d full=%b, expected 1/0/%0d/1",
                     saw_err, saw_strobe, count, full, DEPTH);
        end
        for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    endtask

    task automatic test_illegal();
        reset_cycle();
        clear_logs();
        set_req(2, 1, 4, 0);
        step();
        n_cmp++;
        if ({saw_err, saw_strobe, count} !== {1'b1, 1'b0, CNT_W'(0)}) begin
            n_bad++;
            $display("FAIL deq_when_empty: err=%b strobe=%b count=%0d, expected 1/0/0", saw_err, saw_strobe, count);
        end
        set_req(0, 0, 1, 32'hABCD);
        step(); step(); step();
        clear_logs();
        set_req(1, 3, 6, 32'h1);
        step(); step();
        n_cmp++;
        if ({saw_err, saw_strobe, count} !== {1'b1, 1'b0, CNT_W'(1)}) begin
            n_bad++;
            $display("FAIL reserved_op: err=%b strobe=%b count=%0d, expected 1/0/1", saw_err, saw_strobe, count);
        end
    endtask

    task automatic test_remove();
        rhit = 0;
        set_req(1, 2, 5, $urandom);
        step(); step(); step();
        n_cmp++;
        if (count !== CNT_W'(1)) begin
            n_bad++;
            $display("FAIL remove_miss: count=%0d, expected 1", count);
        end
        rhit = 1;
        set_req(3, 2, 5, $urandom);
        step(); step(); step();
        rhit = 0;
        n_cmp++;
        if ({count, empty} !== {CNT_W'(0), 1'b1}) begin
            n_bad++;
            $display("FAIL remove_hit: count=%0d empty=%b, expected 0/1", count, empty);
        end
    endtask

    task automatic test_reset_mid();
        reset_cycle();
        clear_logs();
        set_req(2, 0, 9, 32'h77);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        saw_strobe = 0;
        step();
        n_cmp++;
        if ({saw_strobe, count, empty} !== {1'b0, CNT_W'(0), 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_op: strobe=%b count=%0d empty=%b, expected 0/0/1", saw_strobe, count, empty);
        end
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, i, 0);
        step();
        n_cmp++;
        if (grant_who.size() !== 1 || grant_who[0] !== 0) begin
            n_bad++;
            $display("FAIL reset_rr_ptr: grants=%0d first=%0d, expected one grant to req0",
                     grant_who.size(), (grant_who.size() > 0) ? grant_who[0] : -1);
        end
        for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
        step(); step();
    endtask

    task automatic test_random();
        int r;
        reset_cycle();
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 9);
                    set_req(i, (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3, $urandom_range(0, 15), $urandom);
                end else if (p_valid[i] && $urandom_range(0, 7) == 0) begin
                    p_op[i] = $urandom_range(0, 3); p_tid[i] = $urandom_range(0, 15); p_info[i] = $urandom;
                end
            end
            rhit = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_enq();
        test_round_robin();
        test_full();
        test_illegal();
        test_remove();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
